// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared control-word type, writeback and forwarding encodings
package riscv_ctrl_pkg;
  localparam logic [1:0] DSEL_MEM = 2'b00;
  localparam logic [1:0] DSEL_ALU = 2'b01;
  localparam logic [1:0] DSEL_PC4 = 2'b10;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef struct packed {
    logic       reg_wen;
    logic       mem_wen;
    logic       a_src;
    logic       b_src;
    logic [1:0] dsel;
    logic [1:0] alu_con;
    logic       branch;
    logic       jump;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, redirect flush and operand forwarding selects
module hazard_unit import riscv_ctrl_pkg::*; #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              reg_wen_e_i,
  input  logic [1:0]        dsel_e_i,
  input  logic [REG_AW-1:0] rd_e_i,
  input  logic [REG_AW-1:0] rs1_e_i,
  input  logic [REG_AW-1:0] rs2_e_i,
  input  logic [REG_AW-1:0] rs1_d_i,
  input  logic [REG_AW-1:0] rs2_d_i,
  input  logic              pcsrc_e_i,
  input  logic              reg_wen_m_i,
  input  logic [1:0]        dsel_m_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              reg_wen_w_i,
  input  logic [REG_AW-1:0] rd_w_i,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              flush_d_o,
  output logic              flush_e_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);
  logic lw_stall;
  // Only ALU results are available in M; anything else falls through to W
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    return !FWD_EN ? FWD_RF :
           (reg_wen_m_i && rd_m_i != '0 && rd_m_i == rs && dsel_m_i == DSEL_ALU) ? FWD_MEM :
           (reg_wen_w_i && rd_w_i != '0 && rd_w_i == rs) ? FWD_WB : FWD_RF;
  endfunction
  always_comb begin
    lw_stall  = reg_wen_e_i && dsel_e_i == DSEL_MEM && rd_e_i != '0 &&
                (rd_e_i == rs1_d_i || rd_e_i == rs2_d_i);
    stall_f_o = lw_stall;
    stall_d_o = lw_stall;
    flush_d_o = pcsrc_e_i;
    flush_e_o = lw_stall || pcsrc_e_i;
    fwd_a_o   = fwd_sel(rs1_e_i);
    fwd_b_o   = fwd_sel(rs2_e_i);
  end
endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: ID/EX, EX/MEM, MEM/WB control registers, PCSrc resolution and hazard control
module ctrl_pipeline import riscv_ctrl_pkg::*; #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWEnD,
  input  logic              MemWEnD,
  input  logic              ASrcD,
  input  logic              BSrcD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic [1:0]        DdataSelD,
  input  logic [1:0]        ALUconD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              BAE,
  output logic              ASrcE,
  output logic              BSrcE,
  output logic [1:0]        ALUconE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              PCSrcE,
  output logic              MemWEnM,
  output logic              RegWEnW,
  output logic [1:0]        DdataSelW,
  output logic [REG_AW-1:0] RdW,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE
);
  ctrl_t             ctrl_d, ctrl_e_d, ctrl_e_q;
  logic [REG_AW-1:0] rs1_e_d, rs2_e_d, rd_e_d, rs1_e_q, rs2_e_q, rd_e_q, rd_m_q, rd_w_q;
  logic              reg_wen_m_q, mem_wen_m_q, reg_wen_w_q;
  logic [1:0]        dsel_m_q, dsel_w_q;
  assign ctrl_d = '{reg_wen: RegWEnD, mem_wen: MemWEnD, a_src: ASrcD, b_src: BSrcD,
                    dsel: DdataSelD, alu_con: ALUconD, branch: BranchD, jump: JumpD};
  always_comb begin
    ctrl_e_d = FlushE ? CTRL_BUBBLE : ctrl_d;
    rs1_e_d  = FlushE ? '0 : Rs1D;
    rs2_e_d  = FlushE ? '0 : Rs2D;
    rd_e_d   = FlushE ? '0 : RdD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_e_q    <= CTRL_BUBBLE;
      rs1_e_q     <= '0;
      rs2_e_q     <= '0;
      rd_e_q      <= '0;
      reg_wen_m_q <= 1'b0;
      mem_wen_m_q <= 1'b0;
      dsel_m_q    <= DSEL_MEM;
      rd_m_q      <= '0;
      reg_wen_w_q <= 1'b0;
      dsel_w_q    <= DSEL_MEM;
      rd_w_q      <= '0;
    end else begin
      ctrl_e_q    <= ctrl_e_d;
      rs1_e_q     <= rs1_e_d;
      rs2_e_q     <= rs2_e_d;
      rd_e_q      <= rd_e_d;
      reg_wen_m_q <= ctrl_e_q.reg_wen;
      mem_wen_m_q <= ctrl_e_q.mem_wen;
      dsel_m_q    <= ctrl_e_q.dsel;
      rd_m_q      <= rd_e_q;
      reg_wen_w_q <= reg_wen_m_q;
      dsel_w_q    <= dsel_m_q;
      rd_w_q      <= rd_m_q;
    end
  end
  assign ASrcE     = ctrl_e_q.a_src;
  assign BSrcE     = ctrl_e_q.b_src;
  assign ALUconE   = ctrl_e_q.alu_con;
  assign PCSrcE    = (BAE & ctrl_e_q.branch) | ctrl_e_q.jump;
  assign MemWEnM   = mem_wen_m_q;
  assign RegWEnW   = reg_wen_w_q;
  assign DdataSelW = dsel_w_q;
  assign RdW       = rd_w_q;
  hazard_unit #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_hazard (
    .reg_wen_e_i (ctrl_e_q.reg_wen),
    .dsel_e_i    (ctrl_e_q.dsel),
    .rd_e_i      (rd_e_q),
    .rs1_e_i     (rs1_e_q),
    .rs2_e_i     (rs2_e_q),
    .rs1_d_i     (Rs1D),
    .rs2_d_i     (Rs2D),
    .pcsrc_e_i   (PCSrcE),
    .reg_wen_m_i (reg_wen_m_q),
    .dsel_m_i    (dsel_m_q),
    .rd_m_i      (rd_m_q),
    .reg_wen_w_i (reg_wen_w_q),
    .rd_w_i      (rd_w_q),
    .stall_f_o   (StallF),
    .stall_d_o   (StallD),
    .flush_d_o   (FlushD),
    .flush_e_o   (FlushE),
    .fwd_a_o     (ForwardAE),
    .fwd_b_o     (ForwardBE)
  );
endmodule
